// File: rtl/te_block_packer.sv
// Packs retired uops from several commit ports into instruction-block records
// and queues them in a small FIFO drained by the trace encoder.
module te_block_packer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned IRETIRE_W       = 32,
    parameter int unsigned ITYPE_LEN       = 3,
    parameter int unsigned PRIV_LEN        = 2,
    // Per-port uop layout, MSB to LSB: valid, pc, itype, compressed, priv
    localparam int unsigned UopW           = 1 + XLEN + ITYPE_LEN + 1 + PRIV_LEN
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NR_COMMIT_PORTS*UopW-1:0] uop_entry_i,
    input  logic [XLEN-1:0]                 cause_i,
    input  logic [XLEN-1:0]                 tval_i,
    input  logic                            ready_i,
    output logic                            valid_o,
    output logic [IRETIRE_W-1:0]            iretire_o,
    output logic                            ilastsize_o,
    output logic [ITYPE_LEN-1:0]            itype_o,
    output logic [XLEN-1:0]                 cause_o,
    output logic [XLEN-1:0]                 tval_o,
    output logic [PRIV_LEN-1:0]             priv_o,
    output logic [XLEN-1:0]                 iaddr_o,
    output logic                            full_o,
    output logic                            drop_o
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned MaxRec = 2 * NR_COMMIT_PORTS;

    typedef enum logic {StIdle, StCount} state_e;

    typedef struct packed {
        logic [ITYPE_LEN-1:0] itype;
        logic [XLEN-1:0]      cause;
        logic [XLEN-1:0]      tval;
        logic [IRETIRE_W-1:0] iretire;
        logic                 ilastsize;
        logic [PRIV_LEN-1:0]  priv;
        logic [XLEN-1:0]      iaddr;
    } rec_t;

    function automatic rec_t mk_rec(input logic [ITYPE_LEN-1:0] it,
                                    input logic [XLEN-1:0] cause,
                                    input logic [XLEN-1:0] tval,
                                    input logic [IRETIRE_W-1:0] iretire,
                                    input logic ls,
                                    input logic [PRIV_LEN-1:0] priv,
                                    input logic [XLEN-1:0] iaddr);
        rec_t r;
        r.itype     = it;
        r.cause     = cause;
        r.tval      = tval;
        r.iretire   = iretire;
        r.ilastsize = ls;
        r.priv      = priv;
        r.iaddr     = iaddr;
        return r;
    endfunction

    logic [NR_COMMIT_PORTS-1:0] u_valid;
    logic [NR_COMMIT_PORTS-1:0] u_comp;
    logic [XLEN-1:0]            u_pc    [NR_COMMIT_PORTS];
    logic [ITYPE_LEN-1:0]       u_itype [NR_COMMIT_PORTS];
    logic [PRIV_LEN-1:0]        u_priv  [NR_COMMIT_PORTS];

    state_e               state_q, state_d;
    logic [IRETIRE_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      iaddr_q, iaddr_d;
    logic                 lastsize_q, lastsize_d;
    logic [IRETIRE_W:0]   inc, sum;
    logic                 trap;
    rec_t                 recs [MaxRec];
    int unsigned          n_rec;

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   occ_q, occ_d;
    rec_t            mem_q [FIFO_DEPTH];
    logic            drop_q;
    logic            pop;
    int unsigned     free, n_push;
    rec_t            head;

    always_comb begin
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            {u_valid[k], u_pc[k], u_itype[k], u_comp[k], u_priv[k]} =
                uop_entry_i[k*UopW +: UopW];
        end
    end

    // Block state chains through the ports oldest first within one cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        iaddr_d    = iaddr_q;
        lastsize_d = lastsize_q;
        inc        = '0;
        sum        = '0;
        n_rec      = 0;
        for (int i = 0; i < MaxRec; i++) recs[i] = '0;
        trap = (u_itype[0] == ITYPE_LEN'(1)) || (u_itype[0] == ITYPE_LEN'(2));

        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (k == 0 || !trap) begin
                if (u_valid[k]) begin
                    inc = u_comp[k] ? (IRETIRE_W+1)'(1) : (IRETIRE_W+1)'(2);
                    sum = {1'b0, cnt_d} + inc;
                    if (state_d == StCount && sum[IRETIRE_W]) begin
                        recs[n_rec] = mk_rec('0, '0, '0, cnt_d, lastsize_d, '0, iaddr_d);
                        n_rec       = n_rec + 1;
                        state_d     = StIdle;
                    end
                    if (state_d == StIdle) begin
                        iaddr_d = u_pc[k];
                        cnt_d   = inc[IRETIRE_W-1:0];
                    end else begin
                        cnt_d = sum[IRETIRE_W-1:0];
                    end
                    lastsize_d = !u_comp[k];
                    state_d    = StCount;
                end
                if (k == 0 && trap) begin
                    recs[n_rec] = mk_rec(u_itype[0], cause_i,
                                         (u_itype[0] == ITYPE_LEN'(1)) ? tval_i : '0,
                                         (state_d == StCount) ? cnt_d : '0,
                                         lastsize_d,
                                         u_valid[0] ? u_priv[0] : '0,
                                         iaddr_d);
                    n_rec   = n_rec + 1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (u_valid[k] && u_itype[k] > ITYPE_LEN'(2)) begin
                    recs[n_rec] = mk_rec(u_itype[k], '0, '0, cnt_d, lastsize_d,
                                         u_priv[k], iaddr_d);
                    n_rec   = n_rec + 1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
        end
    end

    // Excess records are dropped youngest first; the popped slot counts as free.
    always_comb begin
        pop    = (occ_q != '0) && ready_i;
        free   = FIFO_DEPTH - 32'(occ_q) + 32'(pop);
        n_push = (n_rec > free) ? free : n_rec;
        occ_d  = occ_q + (PtrW+1)'(n_push) - (PtrW+1)'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            iaddr_q    <= '0;
            lastsize_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            drop_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iaddr_q    <= iaddr_d;
            lastsize_q <= lastsize_d;
            for (int unsigned i = 0; i < MaxRec; i++) begin
                if (i < n_push) mem_q[wr_ptr_q + PtrW'(i)] <= recs[i];
            end
            wr_ptr_q <= wr_ptr_q + PtrW'(n_push);
            rd_ptr_q <= rd_ptr_q + PtrW'(pop);
            occ_q    <= occ_d;
            drop_q   <= (n_rec > free);
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign valid_o     = (occ_q != '0);
    assign iretire_o   = head.iretire;
    assign ilastsize_o = head.ilastsize;
    assign itype_o     = head.itype;
    assign cause_o     = head.cause;
    assign tval_o      = head.tval;
    assign priv_o      = head.priv;
    assign iaddr_o     = head.iaddr;
    assign full_o      = (FIFO_DEPTH - 32'(occ_q)) < NR_COMMIT_PORTS;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_te_block_packer.sv
// Directed scoreboard bench for te_block_packer (2 ports, depth 4, 4-bit iretire).
module tb_te_block_packer;

    localparam int unsigned NP  = 2;
    localparam int unsigned DEP = 4;
    localparam int unsigned XL  = 32;
    localparam int unsigned IW  = 4;
    localparam int unsigned ITL = 3;
    localparam int unsigned PL  = 2;
    localparam int unsigned UW  = 1 + XL + ITL + 1 + PL;

    typedef struct packed {
        logic [ITL-1:0] itype;
        logic [XL-1:0]  cause;
        logic [XL-1:0]  tval;
        logic [IW-1:0]  iretire;
        logic           ilastsize;
        logic [PL-1:0]  priv;
        logic [XL-1:0]  iaddr;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*UW-1:0] uop;
    logic [XL-1:0]    cause, tval;
    logic             ready;
    logic             valid_o, ilastsize_o, full_o, drop_o;
    logic [IW-1:0]    iretire_o;
    logic [ITL-1:0]   itype_o;
    logic [XL-1:0]    cause_o, tval_o, iaddr_o;
    logic [PL-1:0]    priv_o;
    rec_t             head;
    rec_t             exp_q[$];
    int unsigned      n_checks = 0;
    int unsigned      n_pass = 0;

    always #5 clk = ~clk;

    te_block_packer #(
        .NR_COMMIT_PORTS(NP),
        .FIFO_DEPTH     (DEP),
        .XLEN           (XL),
        .IRETIRE_W      (IW),
        .ITYPE_LEN      (ITL),
        .PRIV_LEN       (PL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .uop_entry_i(uop),
        .cause_i    (cause),
        .tval_i     (tval),
        .ready_i    (ready),
        .valid_o    (valid_o),
        .iretire_o  (iretire_o),
        .ilastsize_o(ilastsize_o),
        .itype_o    (itype_o),
        .cause_o    (cause_o),
        .tval_o     (tval_o),
        .priv_o     (priv_o),
        .iaddr_o    (iaddr_o),
        .full_o     (full_o),
        .drop_o     (drop_o)
    );

    assign head = {itype_o, cause_o, tval_o, iretire_o, ilastsize_o, priv_o, iaddr_o};

    function automatic logic [UW-1:0] u(input logic v, input logic [XL-1:0] pc,
                                        input logic [ITL-1:0] it, input logic c,
                                        input logic [PL-1:0] pr);
        return {v, pc, it, c, pr};
    endfunction

    function automatic rec_t mk(input logic [ITL-1:0] it, input logic [XL-1:0] ca,
                                input logic [XL-1:0] tv, input logic [IW-1:0] ir,
                                input logic ls, input logic [PL-1:0] pr,
                                input logic [XL-1:0] ia);
        return {it, ca, tv, ir, ls, pr, ia};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    endtask

    // Compare the head against the scoreboard whenever it is consumed, then advance a cycle.
    task automatic step();
        rec_t e;
        if (valid_o && ready) begin
            check("record_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("record", 128'(head), 128'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        uop   = '0;
        cause = 32'h55;
        tval  = 32'h66;
        ready = 1'b1;
        step();
        step();
        check("reset_valid", 128'(valid_o), 128'(0));
        check("reset_full", 128'(full_o), 128'(0));
        check("reset_drop", 128'(drop_o), 128'(0));
        check("reset_head", 128'(head), 128'(0));
        rst = 1'b0;
        step();

        // Two-port block closed by a 16-bit branch next cycle
        uop = {u(1, 32'h1004, 0, 1, 3), u(1, 32'h1000, 0, 0, 3)};
        step();
        uop = {u(0, 0, 0, 0, 0), u(1, 32'h1006, 4, 1, 3)};
        exp_q.push_back(mk(4, 0, 0, 4, 0, 3, 32'h1000));
        step();
        check("t1_latency_valid", 128'(valid_o), 128'(1));
        uop = '0;
        step();
        step();

        // Exception on port 0; port 1 must be ignored
        cause = 32'h2;
        tval  = 32'hdead;
        uop   = {u(1, 32'h2004, 4, 1, 1), u(1, 32'h2000, 1, 0, 1)};
        exp_q.push_back(mk(1, 32'h2, 32'hdead, 2, 1, 1, 32'h2000));
        step();
        cause = 32'h55;
        tval  = 32'h66;
        uop   = '0;
        step();
        step();

        // Interrupt with no valid instruction after a block ending 16-bit at 0x3000
        uop = {u(0, 0, 0, 0, 0), u(1, 32'h3000, 3, 1, 3)};
        exp_q.push_back(mk(3, 0, 0, 1, 0, 3, 32'h3000));
        step();
        cause = 32'h8000_0007;
        tval  = 32'h1234;
        uop   = {u(0, 0, 0, 0, 0), u(0, 0, 2, 0, 0)};
        exp_q.push_back(mk(2, 32'h8000_0007, 0, 0, 0, 0, 32'h3000));
        step();
        cause = 32'h55;
        tval  = 32'h66;
        uop   = '0;
        step();
        step();

        // Saturation at 15 halfwords: the 8th 32-bit instruction flushes and reopens
        for (int i = 0; i < 4; i++) begin
            uop = {u(1, 32'h4004 + 32'(8 * i), 0, 0, 0), u(1, 32'h4000 + 32'(8 * i), 0, 0, 0)};
            if (i == 3) exp_q.push_back(mk(0, 0, 0, 14, 1, 0, 32'h4000));
            step();
        end
        uop = {u(0, 0, 0, 0, 0), u(1, 32'h4020, 4, 0, 3)};
        exp_q.push_back(mk(4, 0, 0, 4, 1, 3, 32'h401c));
        step();
        uop = '0;
        step();
        step();

        // Backpressure: six records offered into a depth-4 FIFO
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            uop = {u(1, 32'h5002 + 32'(4 * i), 4, 1, 2), u(1, 32'h5000 + 32'(4 * i), 4, 1, 2)};
            if (i < 2) begin
                exp_q.push_back(mk(4, 0, 0, 1, 0, 2, 32'h5000 + 32'(4 * i)));
                exp_q.push_back(mk(4, 0, 0, 1, 0, 2, 32'h5002 + 32'(4 * i)));
            end
            step();
            if (i == 0) check("t5_not_full", 128'(full_o), 128'(0));
            if (i == 1) begin
                check("t5_full", 128'(full_o), 128'(1));
                check("t5_no_drop_yet", 128'(drop_o), 128'(0));
            end
            if (i == 2) begin
                check("t5_drop", 128'(drop_o), 128'(1));
                check("t5_head_hold", 128'(iaddr_o), 128'(32'h5000));
                check("t5_valid", 128'(valid_o), 128'(1));
            end
        end
        uop = '0;
        step();
        check("t5_drop_pulse", 128'(drop_o), 128'(0));
        check("t5_still_full", 128'(full_o), 128'(1));
        ready = 1'b1;
        repeat (5) step();
        check("t5_drained_full", 128'(full_o), 128'(0));

        // Reset mid-block with three queued records
        ready = 1'b0;
        uop   = {u(1, 32'h6002, 4, 1, 0), u(1, 32'h6000, 4, 1, 0)};
        step();
        uop = {u(1, 32'h6006, 0, 0, 0), u(1, 32'h6004, 3, 1, 0)};
        step();
        check("t6_queued", 128'(valid_o), 128'(1));
        uop = '0;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 128'(valid_o), 128'(0));
        check("t6_rst_full", 128'(full_o), 128'(0));
        exp_q.delete();
        step();
        rst   = 1'b0;
        ready = 1'b1;
        uop   = {u(0, 0, 0, 0, 0), u(1, 32'h7000, 4, 0, 3)};
        exp_q.push_back(mk(4, 0, 0, 2, 1, 3, 32'h7000));
        step();
        uop = '0;
        step();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/te_block_packer.md
# te_block_packer

Parametrised multi-commit-port successor to the single-port connector FSM. It takes up to NR_COMMIT_PORTS retired uops per cycle from the CVA6 commit stage and accumulates them into instruction blocks (iaddr, iretire, ilastsize). A block closes on a special instruction, a trap, or counter saturation. Each closed block becomes one record in an output FIFO, which the trace encoder drains through a valid/ready handshake.

## Interface
- NR_COMMIT_PORTS, default 2: commit ports processed per cycle; port 0 is oldest.
- FIFO_DEPTH, default 4: output record entries; must be ≥ NR_COMMIT_PORTS+1, power of two.
- IRETIRE_W, default connector_pkg::IRETIRE_LEN: iretire counter width, in halfwords.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- uop_entry_i  in  NR_COMMIT_PORTS x connector_pkg::uop_entry_s  per-port fields: valid, pc, itype, compressed, priv.
- cause_i  in  XLEN  trap cause; sampled only when port 0 itype is 1 or 2.
- tval_i  in  XLEN  trap value; sampled only when port 0 itype is 1.
- ready_i  in  1  consumer accepts the head record.
- valid_o  out  1  head record available (FIFO not empty).
- iretire_o  out  IRETIRE_W  halfwords retired in the block.
- ilastsize_o  out  1  1 = last instruction of the block was 32-bit.
- itype_o  out  ITYPE_LEN  block-closing type; 0 = saturation flush.
- cause_o, tval_o  out  XLEN  trap cause and tval; 0 when not a trap.
- priv_o  out  PRIV_LEN  priv of the closing instruction; 0 for a trap with no valid instruction.
- iaddr_o  out  XLEN  pc of the first instruction in the block.
- full_o  out  1  fewer than NR_COMMIT_PORTS free entries.
- drop_o  out  1  one-cycle pulse: at least one record was lost this cycle.

## Operation
- State: IDLE (no open block) or COUNT (open block). Registers: cnt_q, iaddr_q, lastsize_q.
- Ports are evaluated in index order within one cycle; the state chains combinationally from port k to port k+1.
- Port k contributes when valid: inc = compressed ? 1 : 2. In IDLE the port opens a block: iaddr = pc, cnt = inc. In COUNT: cnt += inc. lastsize = !compressed.
- Saturation: if cnt + inc > 2^IRETIRE_W−1, first emit {itype 0, cnt, lastsize, iaddr}, then open a new block with this instruction.
- Special instruction (valid, itype > 2): included in the block, then the block is emitted with itype and priv → IDLE.
- Trap (itype 1 or 2) is honoured on port 0 only. Ports ≥1 are ignored that cycle.
  - If port 0 is valid, its instruction is included in the block first.
  - Emits {itype, cause_i, tval_i (exceptions only), cnt, lastsize, iaddr} → IDLE.
  - If port 0 is invalid and no block is open: emits iretire = 0, with the stored lastsize_q and iaddr_q.
- Itype > 0 on ports ≥1 without valid is ignored.
- Up to NR_COMMIT_PORTS+1 records can be produced per cycle; they are pushed oldest first.
- free = FIFO_DEPTH − occupancy + (valid_o && ready_i).
- Records beyond free are discarded youngest first and drop_o is asserted. Block state still advances as if every record had been pushed.
- Pop on valid_o && ready_i. The head record holds stable while valid_o && !ready_i.

## Timing
- Reset: FIFO empty, IDLE, cnt_q/iaddr_q/lastsize_q = 0, all outputs 0.
- Push-to-output latency is 1 cycle: a record closed in cycle t is visible on valid_o at t+1 when the FIFO was empty. No combinational input→output path.
- Simultaneous push and pop at full is allowed; the popped slot is reusable in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit counter.
- full_o and drop_o are registered-state functions: full_o derives from occupancy, drop_o is registered one cycle after the loss.
- Reset asserted mid-block discards the open block and all FIFO contents asynchronously.

## Test plan
- Two ports, 32-bit std inst at 0x1000 and 16-bit at 0x1004, next cycle port 0 branch (itype 4, 16-bit) → one record: iaddr 0x1000, iretire 4, ilastsize 0, itype 4, valid_o at next cycle.
- Port 0 valid 32-bit at 0x2000 with itype 1, cause 2, tval 0xdead; port 1 valid → record: iretire 2, ilastsize 1, cause 2, tval 0xdead; port 1 ignored.
- Interrupt (itype 2, cause 0x8000..07) in IDLE with no valid, after a prior block ended 16-bit at 0x3000 → iretire 0, ilastsize 0, iaddr 0x3000.
- IRETIRE_W = 4: eight 32-bit std instructions → itype-0 record with iretire 14 at the 8th instruction, new block opened with cnt 2.
- ready_i held 0, branches on both ports for 3 cycles (DEPTH 4) → full_o rises, 2 records dropped, drop_o pulses, head record unchanged.
- rst_i pulsed mid-COUNT with 3 queued records → valid_o 0 immediately; the next instruction opens a fresh block.
